ring_input_buffer: RTL and testbench

RING_INPUT_BUFFER -- requirements
Module: ring_input_buffer

---
 rtl/ring_pkg.sv | 25 ++
 rtl/ring_slot_bank.sv | 88 ++++++++
 rtl/ring_input_buffer.sv | 86 ++++++++
 tb/tb_ring_input_buffer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared packet layout, route codes and default sizing for the ring input buffer.
package ring_pkg;

    localparam int unsigned DEFAULT_PACKET_SIZE = 49;
    localparam int unsigned DEFAULT_BUFFER_SIZE = 4;

    localparam int unsigned VALID_BIT   = 48;
    localparam int unsigned TS_MSB      = 47;
    localparam int unsigned TS_LSB      = 32;
    localparam int unsigned DEST_MSB    = 31;
    localparam int unsigned DEST_LSB    = 16;
    localparam int unsigned PAYLOAD_MSB = 15;
    localparam int unsigned PAYLOAD_LSB = 0;

    typedef enum logic [15:0] {
        RouteNone  = 16'd0,
        RouteFwd   = 16'd1,
        RouteEject = 16'd2
    } route_e;

    function automatic route_e route_code(input logic [15:0] dest, input logic [15:0] node_id);
        return (dest == node_id) ? RouteEject : RouteFwd;
    endfunction

endpackage

// File: rtl/ring_slot_bank.sv
// One priority class: slot storage, lowest-free-slot encoder, occupancy count
// and grant-driven slot release.
module ring_slot_bank
    import ring_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = DEFAULT_PACKET_SIZE,
    parameter int unsigned BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
    parameter logic [15:0] NODE_ID     = 16'd0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [PACKET_SIZE-1:0]                  wr_pkt,
    input  logic                                    rel_valid,
    input  logic [15:0]                             rel_pos,
    output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] slots,
    output logic [BUFFER_SIZE-1:0][15:0]            routes,
    output logic [2:0]                              count,
    output logic                                    ready,
    output logic                                    rel_err
);

    localparam int unsigned IdxW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

    logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] slot_q, slot_d;
    logic [BUFFER_SIZE-1:0][15:0]            route_q, route_d;
    logic [2:0]                              count_q, count_d;
    logic [BUFFER_SIZE-1:0]                  occupied;
    logic [IdxW-1:0]                         free_idx;
    logic [IdxW-1:0]                         rel_idx;
    logic                                    pos_in_range;
    logic                                    accept;
    logic                                    rel_ok;

    // Every stored packet was accepted with its valid bit set, so that bit marks occupancy.
    always_comb begin
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            occupied[i] = slot_q[i][VALID_BIT];
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = BUFFER_SIZE - 1; i >= 0; i--) begin
            if (!occupied[i]) begin
                free_idx = IdxW'(i);
            end
        end
    end

    assign ready        = ~&occupied;
    assign accept       = wr_pkt[VALID_BIT] && ready;
    assign pos_in_range = rel_pos < 16'(BUFFER_SIZE);
    assign rel_idx      = rel_pos[IdxW-1:0];
    assign rel_ok       = rel_valid && pos_in_range && occupied[rel_idx];
    assign rel_err      = rel_valid && !rel_ok;

    // The write slot is empty and the released slot is occupied, so they never collide.
    always_comb begin
        slot_d  = slot_q;
        route_d = route_q;
        count_d = count_q + 3'(accept) - 3'(rel_ok);
        if (rel_ok) begin
            slot_d[rel_idx]  = '0;
            route_d[rel_idx] = RouteNone;
        end
        if (accept) begin
            slot_d[free_idx]  = wr_pkt;
            route_d[free_idx] = route_code(wr_pkt[DEST_MSB:DEST_LSB], NODE_ID);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            route_q <= '0;
            count_q <= '0;
        end else begin
            slot_q  <= slot_d;
            route_q <= route_d;
            count_q <= count_d;
        end
    end

    assign slots  = slot_q;
    assign routes = route_q;
    assign count  = count_q;

endmodule

// File: rtl/ring_input_buffer.sv
// Ring router input stage: ring traffic goes to the high class, local injections
// (restamped with the local timestamp) to the low class.
module ring_input_buffer
    import ring_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = DEFAULT_PACKET_SIZE,
    parameter int unsigned BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
    parameter logic [15:0] NODE_ID     = 16'd0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [PACKET_SIZE-1:0]                  ring_in,
    output logic                                    ring_ready,
    input  logic [PACKET_SIZE-1:0]                  local_in,
    output logic                                    local_ready,
    output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_high_prior,
    output logic [BUFFER_SIZE-1:0][PACKET_SIZE-1:0] buffer_low_prior,
    output logic [BUFFER_SIZE-1:0][15:0]            buffer_high_prior_route_info,
    output logic [BUFFER_SIZE-1:0][15:0]            buffer_low_prior_route_info,
    input  logic [15:0]                             grant_pos,
    input  logic                                    grant_valid,
    input  logic                                    grant_in_high,
    output logic [2:0]                              high_count,
    output logic [2:0]                              low_count,
    output logic                                    grant_err
);

    localparam logic [PACKET_SIZE-1:0] TsMask = PACKET_SIZE'(17'h0FFFF) << TS_LSB;

    logic [15:0]            ts_q, ts_d;
    logic                   err_q, err_d;
    logic [PACKET_SIZE-1:0] local_pkt;
    logic                   high_rel_err;
    logic                   low_rel_err;

    assign ts_d      = ts_q + 16'd1;
    assign local_pkt = (local_in & ~TsMask) | (PACKET_SIZE'(ts_q) << TS_LSB);
    assign err_d     = err_q | high_rel_err | low_rel_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q  <= '0;
            err_q <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            err_q <= err_d;
        end
    end

    assign grant_err = err_q;

    ring_slot_bank #(
        .PACKET_SIZE (PACKET_SIZE),
        .BUFFER_SIZE (BUFFER_SIZE),
        .NODE_ID     (NODE_ID)
    ) u_high_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_pkt    (ring_in),
        .rel_valid (grant_valid && grant_in_high),
        .rel_pos   (grant_pos),
        .slots     (buffer_high_prior),
        .routes    (buffer_high_prior_route_info),
        .count     (high_count),
        .ready     (ring_ready),
        .rel_err   (high_rel_err)
    );

    ring_slot_bank #(
        .PACKET_SIZE (PACKET_SIZE),
        .BUFFER_SIZE (BUFFER_SIZE),
        .NODE_ID     (NODE_ID)
    ) u_low_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_pkt    (local_pkt),
        .rel_valid (grant_valid && !grant_in_high),
        .rel_pos   (grant_pos),
        .slots     (buffer_low_prior),
        .routes    (buffer_low_prior_route_info),
        .count     (low_count),
        .ready     (local_ready),
        .rel_err   (low_rel_err)
    );

endmodule

// File: tb/tb_ring_input_buffer.sv
// Self-checking bench for ring_input_buffer: array-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_ring_input_buffer;

    localparam int unsigned PS  = 49;
    localparam int unsigned BS  = 4;
    localparam logic [15:0] NID = 16'd3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [PS-1:0]          ring_in;
    logic [PS-1:0]          local_in;
    logic                   ring_ready;
    logic                   local_ready;
    logic [BS-1:0][PS-1:0]  buffer_high_prior;
    logic [BS-1:0][PS-1:0]  buffer_low_prior;
    logic [BS-1:0][15:0]    buffer_high_prior_route_info;
    logic [BS-1:0][15:0]    buffer_low_prior_route_info;
    logic [15:0]            grant_pos;
    logic                   grant_valid;
    logic                   grant_in_high;
    logic [2:0]             high_count;
    logic [2:0]             low_count;
    logic                   grant_err;

    ring_input_buffer #(
        .PACKET_SIZE (PS),
        .BUFFER_SIZE (BS),
        .NODE_ID     (NID)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .ring_in                      (ring_in),
        .ring_ready                   (ring_ready),
        .local_in                     (local_in),
        .local_ready                  (local_ready),
        .buffer_high_prior            (buffer_high_prior),
        .buffer_low_prior             (buffer_low_prior),
        .buffer_high_prior_route_info (buffer_high_prior_route_info),
        .buffer_low_prior_route_info  (buffer_low_prior_route_info),
        .grant_pos                    (grant_pos),
        .grant_valid                  (grant_valid),
        .grant_in_high                (grant_in_high),
        .high_count                   (high_count),
        .low_count                    (low_count),
        .grant_err                    (grant_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: slot arrays per class, an empty slot is all-zero.
    logic [PS-1:0] m_hi [BS];
    logic [PS-1:0] m_lo [BS];
    logic [15:0]   m_hr [BS];
    logic [15:0]   m_lr [BS];
    logic [15:0]   m_ts;
    logic          m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_route(input logic [PS-1:0] p);
        return (p[31:16] == NID) ? 16'd2 : 16'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BS; i++) begin
            m_hi[i] = '0;
            m_lo[i] = '0;
            m_hr[i] = '0;
            m_lr[i] = '0;
        end
        m_ts  = '0;
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        int            hf;
        int            lf;
        logic [PS-1:0] lp;
        if (rst) return;
        hf = -1;
        lf = -1;
        for (int i = BS - 1; i >= 0; i--) begin
            if (m_hi[i] == '0) hf = i;
            if (m_lo[i] == '0) lf = i;
        end
        if (grant_valid) begin
            if (grant_pos >= BS) begin
                m_err = 1'b1;
            end else if (grant_in_high) begin
                if (m_hi[grant_pos] == '0) m_err = 1'b1;
                else begin
                    m_hi[grant_pos] = '0;
                    m_hr[grant_pos] = '0;
                end
            end else begin
                if (m_lo[grant_pos] == '0) m_err = 1'b1;
                else begin
                    m_lo[grant_pos] = '0;
                    m_lr[grant_pos] = '0;
                end
            end
        end
        if (ring_in[48] && hf >= 0) begin
            m_hi[hf] = ring_in;
            m_hr[hf] = exp_route(ring_in);
        end
        if (local_in[48] && lf >= 0) begin
            lp         = local_in;
            lp[47:32]  = m_ts;
            m_lo[lf]   = lp;
            m_lr[lf]   = exp_route(lp);
        end
        m_ts = m_ts + 16'd1;
    endtask

    always @(negedge clk) begin : compare
        int hc;
        int lc;
        if (chk_en) begin
            hc = 0;
            lc = 0;
            for (int i = 0; i < BS; i++) begin
                check($sformatf("high_slot%0d", i), buffer_high_prior[i], m_hi[i]);
                check($sformatf("low_slot%0d", i), buffer_low_prior[i], m_lo[i]);
                check($sformatf("high_route%0d", i), buffer_high_prior_route_info[i], m_hr[i]);
                check($sformatf("low_route%0d", i), buffer_low_prior_route_info[i], m_lr[i]);
                if (m_hi[i] != '0) hc++;
                if (m_lo[i] != '0) lc++;
            end
            check("high_count", high_count, hc);
            check("low_count", low_count, lc);
            check("ring_ready", ring_ready, hc < BS);
            check("local_ready", local_ready, lc < BS);
            check("grant_err", grant_err, m_err);
        end
    end

    task automatic idle_inputs();
        ring_in       = '0;
        local_in      = '0;
        grant_valid   = 1'b0;
        grant_in_high = 1'b0;
        grant_pos     = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_high_count"}, high_count, 0);
        check({tag, "_low_count"}, low_count, 0);
        check({tag, "_ring_ready"}, ring_ready, 1);
        check({tag, "_local_ready"}, local_ready, 1);
        check({tag, "_grant_err"}, grant_err, 0);
        check({tag, "_high_zero"}, (buffer_high_prior == '0), 1);
        check({tag, "_low_zero"}, (buffer_low_prior == '0), 1);
        check({tag, "_routes_zero"},
              (buffer_high_prior_route_info == '0) && (buffer_low_prior_route_info == '0), 1);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_values("reset");
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        @(negedge clk);
        #1;
        chk_en = 1'b1;
        do_reset();

        // Ring packet to this node lands in high slot 0 with eject route.
        ring_in = {1'b1, 16'h0010, 16'd3, 16'hABCD};
        cycle();
        idle_inputs();
        check("eject_slot0", buffer_high_prior[0], {1'b1, 16'h0010, 16'd3, 16'hABCD});
        check("eject_route0", buffer_high_prior_route_info[0], 16'd2);
        check("eject_count", high_count, 1);

        // Four local injections on timestamps 7..10 fill the low class.
        while (m_ts != 16'd7) cycle();
        for (int k = 0; k < 4; k++) begin
            local_in = {1'b1, 16'h0000, 16'd5, 16'(k)};
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("inj_ts%0d", k), buffer_low_prior[k][47:32], 7 + k);
            check($sformatf("inj_route%0d", k), buffer_low_prior_route_info[k], 16'd1);
        end
        check("inj_local_ready", local_ready, 0);
        check("inj_low_count", low_count, 4);

        // Fifth injection is refused.
        local_in = {1'b1, 16'h0000, 16'd5, 16'h00FF};
        cycle();
        check("fifth_slot3_payload", buffer_low_prior[3][15:0], 16'h0003);
        check("fifth_low_count", low_count, 4);

        // Release slot 2 while the injection is retried; write lands one cycle later.
        grant_valid   = 1'b1;
        grant_in_high = 1'b0;
        grant_pos     = 16'd2;
        cycle();
        grant_valid = 1'b0;
        check("release_slot2", (buffer_low_prior[2] == '0), 1);
        check("release_count", low_count, 3);
        cycle();
        idle_inputs();
        check("retry_payload", buffer_low_prior[2][15:0], 16'h00FF);
        check("retry_ts", buffer_low_prior[2][47:32], 16'd13);
        check("retry_count", low_count, 4);

        // Grant to an empty high slot flags a sticky error and changes nothing.
        grant_valid   = 1'b1;
        grant_in_high = 1'b1;
        grant_pos     = 16'd1;
        cycle();
        idle_inputs();
        check("bad_grant_err", grant_err, 1);
        check("bad_grant_count", high_count, 1);
        check("bad_grant_slot0", buffer_high_prior[0], {1'b1, 16'h0010, 16'd3, 16'hABCD});
        repeat (3) cycle();
        check("bad_grant_sticky", grant_err, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ring_in = {1'($urandom_range(0, 1)), 16'($urandom),
                       ($urandom_range(0, 1) != 0) ? NID : 16'($urandom), 16'($urandom)};
            local_in = {1'($urandom_range(0, 1)), 16'($urandom),
                        ($urandom_range(0, 1) != 0) ? NID : 16'($urandom), 16'($urandom)};
            grant_valid   = ($urandom_range(0, 2) == 0);
            grant_in_high = 1'($urandom_range(0, 1));
            grant_pos     = 16'($urandom_range(0, 4));
            cycle();
        end
        idle_inputs();

        // Asynchronous reset with both classes full.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ring_in  = {1'b1, 16'h1234, 16'd9, 16'(k)};
            local_in = {1'b1, 16'h0000, 16'd3, 16'(k)};
            cycle();
        end
        idle_inputs();
        check("full_high_count", high_count, 4);
        check("full_low_count", low_count, 4);
        check("full_ring_ready", ring_ready, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_values("async");
        cycle();
        rst = 1'b0;

        // Timestamp wrap: 65540 idle edges, then inject.
        repeat (65540) cycle();
        local_in = {1'b1, 16'hBEEF, 16'd5, 16'h0042};
        cycle();
        idle_inputs();
        check("wrap_ts", buffer_low_prior[0][47:32], 16'h0004);
        check("wrap_payload", buffer_low_prior[0][15:0], 16'h0042);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
